fifo_beat_packer: RTL and testbench
===================================

Name: fifo_beat_packer

Overview:
- Drain stage directly downstream of the multi-port read FIFO.
- Each cycle it pops up to NUM_RD head entries and packs them into an accumulator of BEAT_ENTRIES entries.
- It emits a full beat, or a partial beat on timeout or flush, over a valid/ready interface toward the consumer (trace sink / egress).
- It generates the FIFO's contiguous pop vector from the FIFO occupancy count.

Parameters:
- DATA_WIDTH, 4, width of one FIFO entry.
- NUM_RD, 2, FIFO read ports, i.e. max pops per cycle.
- CNT_WIDTH, 4, width of the FIFO occupancy count (FIFO ADDR_SIZE+1).
- BEAT_ENTRIES, 4, entries per output beat; must be >= NUM_RD.
- TIMEOUT, 16, idle cycles with a partial accumulator before forced emit; must be >= 1.
- FILL_W, $clog2(BEAT_ENTRIES+1), width of the fill level and of o_beat_num.

Ports:
- i_clk, in, 1, clock.
- i_reset, in, 1, synchronous active-high reset.
- i_fifo_cnt, in, CNT_WIDTH, FIFO occupancy.
- i_fifo_data, in, NUM_RD x DATA_WIDTH, FIFO head entries; lane j = head+j.
- o_fifo_pop, out, NUM_RD, pop strobes; always thermometer-coded from lane 0.
- i_flush, in, 1, force emit of a partial accumulator.
- o_beat_valid, out, 1, beat available.
- i_beat_ready, in, 1, consumer accepts beat.
- o_beat_data, out, BEAT_ENTRIES x DATA_WIDTH, packed beat; lane 0 = oldest entry.
- o_beat_num, out, FILL_W, valid entries in the beat (1..BEAT_ENTRIES).
- o_busy, out, 1, fill!=0 or beat pending.

Behaviour:
- Reset:
  - Sync active-high; one i_reset cycle suffices.
  - Next edge sets state FILL, fill=0, idle=0, accumulator all zeros.
  - Outputs: o_beat_valid=0, o_beat_num=0, o_beat_data=0, o_fifo_pop=0, o_busy=0.
  - Reset mid-beat discards the accumulator; no beat is emitted.
  - o_fifo_pop is forced 0 while i_reset=1.
- States (enum in package): FILL, EMIT.
- FILL:
  - k = min(NUM_RD, i_fifo_cnt, BEAT_ENTRIES-fill).
  - o_fifo_pop = low k bits set; never gapped, never more than the count.
  - Comparisons are performed at max(CNT_WIDTH, FILL_W)+1 bits; no truncation.
  - i_fifo_data[j] for j<k is written to acc[fill+j] at the edge; fill += k.
  - If fill+k == BEAT_ENTRIES, go to EMIT.
  - Idle counter: cleared when k>0 or fill==0; otherwise increments, saturating at TIMEOUT.
  - When idle reaches TIMEOUT-1 with fill>0 and k==0, go to EMIT at that edge (partial beat).
  - i_flush=1 with fill>0: pops are suppressed (k=0) that cycle; go to EMIT next edge.
  - i_flush with fill==0 is ignored.
- EMIT:
  - o_beat_valid=1; o_beat_data = acc; o_beat_num = fill.
  - Lanes at index >= fill are zero.
  - o_fifo_pop=0.
  - Data and num are held stable until the handshake.
  - On i_beat_ready=1: fill=0, acc cleared to 0, idle=0, return to FILL. The next pop happens no earlier than the following cycle.
  - i_flush in EMIT is ignored.
- All outputs are registered except o_fifo_pop, which is combinational from i_fifo_cnt, fill, state, i_flush and i_reset.
- Latency: entry popped at cycle t appears in o_beat_data with o_beat_valid at t+1 at the earliest (beat completed at t).
- Throughput: max NUM_RD entries/cycle in FILL, plus one EMIT cycle per beat with ready=1.
- Counter widths: fill is FILL_W bits; idle is $clog2(TIMEOUT+1) bits; no wrap.

Decomposition:
- Package fifo_beat_packer_pkg holds:
  - state enum typedef (FILL, EMIT);
  - localparam function computing the thermometer pop mask;
  - min helper.
- One sub-module: beat_idle_timer, the saturating idle counter with clear/enable, output timeout_hit.
- Accumulator and FSM stay in the top module.

Test Plan:
1. Full beat:
   - Stimulus: reset, then cnt=4 with head A,B then C,D; ready=1.
   - Response: pops 2'b11 for two cycles; next cycle valid=1, data {D,C,B,A}, num=4; valid=0 the cycle after.
2. Space limit and odd count:
   - Stimulus: cnt=3.
   - Response: pops 11 then 01 (fill=3). With cnt=5 and fill=3, pop=01 only; pop=10 never occurs.
3. Timeout:
   - Stimulus: fill=3, cnt=0 held.
   - Response: valid rises exactly TIMEOUT=16 cycles after the last pop; num=3; lane3=0.
4. Backpressure:
   - Stimulus: valid with ready=0 for 5 cycles, cnt=8.
   - Response: data and num stable, pops=0 throughout; ready=1 -> valid drops and pops resume the next cycle.
5. Flush:
   - Stimulus: fill=1 with flush=1 and cnt=2.
   - Response: pops=0 that cycle; next cycle num=1. Flush with fill=0 -> no beat, o_busy stays 0.
6. Reset mid-operation:
   - Stimulus: i_reset=1 while valid=1 with fill=4.
   - Response: next cycle valid=0, num=0, data=0, busy=0, pops=0; no beat is accepted afterwards.

Source files
------------

// File: rtl/fifo_beat_packer_pkg.sv
// Shared types and helpers for the FIFO drain / beat packer.
// Holds the state encoding, the thermometer pop-mask builder and an unsigned min.
package fifo_beat_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int unsigned MASK_W = 32;

  function automatic int unsigned umin(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Low k bits set, lane 0 first; callers size-cast to their lane count.
  function automatic logic [MASK_W-1:0] therm_mask(input int unsigned k);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (i < k) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_beat_packer_if.sv
// FIFO-side and consumer-side signals of the beat packer.
// The packer takes the master modport; the FIFO/consumer environment takes slave.
interface fifo_beat_packer_if
  import fifo_beat_packer_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int NUM_RD       = 2,
  parameter int CNT_WIDTH    = 4,
  parameter int BEAT_ENTRIES = 4,
  parameter int FILL_W       = $clog2(BEAT_ENTRIES + 1)
);
  logic [CNT_WIDTH-1:0]                      i_fifo_cnt;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]         i_fifo_data;
  logic [NUM_RD-1:0]                         o_fifo_pop;
  logic                                      i_flush;
  logic                                      o_beat_valid;
  logic                                      i_beat_ready;
  logic [BEAT_ENTRIES-1:0][DATA_WIDTH-1:0]   o_beat_data;
  logic [FILL_W-1:0]                         o_beat_num;
  logic                                      o_busy;

  modport master (
    input  i_fifo_cnt, i_fifo_data, i_flush, i_beat_ready,
    output o_fifo_pop, o_beat_valid, o_beat_data, o_beat_num, o_busy
  );

  modport slave (
    output i_fifo_cnt, i_fifo_data, i_flush, i_beat_ready,
    input  o_fifo_pop, o_beat_valid, o_beat_data, o_beat_num, o_busy
  );
endinterface

// File: rtl/fifo_beat_packer_idle_timer.sv
// Saturating idle counter for the beat packer; flags the cycle on which a
// partial accumulator has been idle long enough to force an emit.
module beat_idle_timer
  import fifo_beat_packer_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_timeout_hit
);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] r_idle;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_idle <= '0;
    end else if (i_enable && (r_idle != IDLE_W'(TIMEOUT))) begin
      r_idle <= r_idle + 1'b1;
    end
  end

  // Fires one cycle early so the EMIT transition lands on the TIMEOUT-th idle edge.
  assign o_timeout_hit = i_enable && (r_idle == IDLE_W'(TIMEOUT - 1));

endmodule

// File: rtl/fifo_beat_packer.sv
// Drains up to NUM_RD FIFO head entries per cycle into a BEAT_ENTRIES-wide
// accumulator and hands out full or partial (timeout/flush) beats.
module fifo_beat_packer
  import fifo_beat_packer_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int NUM_RD       = 2,
  parameter int CNT_WIDTH    = 4,
  parameter int BEAT_ENTRIES = 4,
  parameter int TIMEOUT      = 16,
  parameter int FILL_W       = $clog2(BEAT_ENTRIES + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  fifo_beat_packer_if.master bus
);
  localparam int CMP_W = ((CNT_WIDTH > FILL_W) ? CNT_WIDTH : FILL_W) + 1;

  state_t                                  r_state;
  state_t                                  w_state_nxt;
  logic [FILL_W-1:0]                       r_fill;
  logic [BEAT_ENTRIES-1:0][DATA_WIDTH-1:0] r_acc;
  logic [CMP_W-1:0]                        w_space;
  logic [CMP_W-1:0]                        w_k;
  logic [CMP_W-1:0]                        w_fill_sum;
  logic                                    w_flush_act;
  logic                                    w_idle_clr;
  logic                                    w_timeout_hit;

  always_comb begin
    w_space     = CMP_W'(BEAT_ENTRIES) - CMP_W'(r_fill);
    w_flush_act = (r_state == FILL) && bus.i_flush && (r_fill != '0);
    if (i_reset || (r_state != FILL) || w_flush_act) begin
      w_k = '0;
    end else begin
      w_k = CMP_W'(umin(umin(NUM_RD, 32'(bus.i_fifo_cnt)), 32'(w_space)));
    end
    w_fill_sum     = CMP_W'(r_fill) + w_k;
    bus.o_fifo_pop = NUM_RD'(therm_mask(32'(w_k)));
    w_idle_clr     = (r_state != FILL) || (w_k != '0) || (r_fill == '0);

    w_state_nxt = r_state;
    case (r_state)
      FILL: begin
        if (w_flush_act || (w_fill_sum == CMP_W'(BEAT_ENTRIES)) || w_timeout_hit) begin
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (bus.i_beat_ready) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= FILL;
    else         r_state <= w_state_nxt;
  end

  beat_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_clear       (w_idle_clr),
    .i_enable      (!w_idle_clr),
    .o_timeout_hit (w_timeout_hit)
  );

  // Accumulator: lane fill+j takes head entry j for every popped lane.
  always_ff @(posedge i_clk) begin
    if (i_reset || ((r_state == EMIT) && bus.i_beat_ready)) begin
      r_fill <= '0;
      r_acc  <= '0;
    end else if (r_state == FILL) begin
      r_fill <= FILL_W'(w_fill_sum);
      for (int e = 0; e < BEAT_ENTRIES; e++) begin
        for (int j = 0; j < NUM_RD; j++) begin
          if ((CMP_W'(j) < w_k) && ((CMP_W'(r_fill) + CMP_W'(j)) == CMP_W'(e))) begin
            r_acc[e] <= bus.i_fifo_data[j];
          end
        end
      end
    end
  end

  assign bus.o_beat_valid = (r_state == EMIT);
  assign bus.o_beat_data  = r_acc;
  assign bus.o_beat_num   = r_fill;
  assign bus.o_busy       = (r_fill != '0) || (r_state == EMIT);

endmodule

// File: tb/tb_fifo_beat_packer.sv
// Directed bench for fifo_beat_packer: a cycle table for full/odd/flush beats
// plus hand-written timeout, backpressure and mid-beat reset sequences.
module tb_fifo_beat_packer;
  localparam int DATA_WIDTH   = 4;
  localparam int NUM_RD       = 2;
  localparam int CNT_WIDTH    = 4;
  localparam int BEAT_ENTRIES = 4;
  localparam int TIMEOUT      = 16;
  localparam int FILL_W       = $clog2(BEAT_ENTRIES + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_beat_packer_if #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_RD(NUM_RD), .CNT_WIDTH(CNT_WIDTH),
    .BEAT_ENTRIES(BEAT_ENTRIES), .FILL_W(FILL_W)
  ) bus ();

  fifo_beat_packer #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_RD(NUM_RD), .CNT_WIDTH(CNT_WIDTH),
    .BEAT_ENTRIES(BEAT_ENTRIES), .TIMEOUT(TIMEOUT), .FILL_W(FILL_W)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  cnt;
    logic [7:0]  fdata;
    logic        flush;
    logic        ready;
    logic [1:0]  pop;
    logic        valid;
    logic        busy;
    logic        chk;
    logic [2:0]  num;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [3:0] cnt, input logic [7:0] fdata,
                              input logic flush, input logic ready,
                              input logic [1:0] pop, input logic valid,
                              input logic busy, input logic chk,
                              input logic [2:0] num, input logic [15:0] data);
    vec_t v;
    v.cnt = cnt; v.fdata = fdata; v.flush = flush; v.ready = ready;
    v.pop = pop; v.valid = valid; v.busy = busy; v.chk = chk;
    v.num = num; v.data = data;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cnt, input logic [7:0] fdata,
                       input logic flush, input logic ready);
    bus.i_fifo_cnt   = cnt;
    bus.i_fifo_data  = fdata;
    bus.i_flush      = flush;
    bus.i_beat_ready = ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Cycle table: inputs held for one cycle, outputs checked before the edge.
    vecs[0]  = mk(4, 8'hBA, 0, 1, 2'b11, 0, 0, 1, 0, 16'h0000);
    vecs[1]  = mk(4, 8'hDC, 0, 1, 2'b11, 0, 1, 0, 0, 16'h0000);
    vecs[2]  = mk(4, 8'hFE, 0, 1, 2'b00, 1, 1, 1, 4, 16'hDCBA);
    vecs[3]  = mk(0, 8'h00, 0, 1, 2'b00, 0, 0, 0, 0, 16'h0000);
    vecs[4]  = mk(3, 8'h21, 0, 0, 2'b11, 0, 0, 0, 0, 16'h0000);
    vecs[5]  = mk(1, 8'h43, 0, 0, 2'b01, 0, 1, 0, 0, 16'h0000);
    vecs[6]  = mk(5, 8'h65, 0, 0, 2'b01, 0, 1, 0, 0, 16'h0000);
    vecs[7]  = mk(5, 8'h65, 0, 1, 2'b00, 1, 1, 1, 4, 16'h5321);
    vecs[8]  = mk(0, 8'h00, 0, 1, 2'b00, 0, 0, 0, 0, 16'h0000);
    vecs[9]  = mk(1, 8'h07, 0, 1, 2'b01, 0, 0, 0, 0, 16'h0000);
    vecs[10] = mk(2, 8'h98, 1, 1, 2'b00, 0, 1, 0, 0, 16'h0000);
    vecs[11] = mk(2, 8'h98, 0, 0, 2'b00, 1, 1, 1, 1, 16'h0007);
    vecs[12] = mk(2, 8'h98, 1, 1, 2'b00, 1, 1, 1, 1, 16'h0007);
    vecs[13] = mk(0, 8'h00, 1, 1, 2'b00, 0, 0, 0, 0, 16'h0000);
    vecs[14] = mk(0, 8'h00, 0, 1, 2'b00, 0, 0, 0, 0, 16'h0000);

    rst = 1'b1;
    drive(4, 8'hBA, 0, 1);
    #2;
    check("rst_pop_forced", 32'(bus.o_fifo_pop), 32'h0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].cnt, vecs[i].fdata, vecs[i].flush, vecs[i].ready);
      #1;
      check($sformatf("v%0d_pop", i),   32'(bus.o_fifo_pop),   32'(vecs[i].pop));
      check($sformatf("v%0d_valid", i), 32'(bus.o_beat_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d_busy", i),  32'(bus.o_busy),       32'(vecs[i].busy));
      if (vecs[i].chk) begin
        check($sformatf("v%0d_num", i),  32'(bus.o_beat_num),  32'(vecs[i].num));
        check($sformatf("v%0d_data", i), 32'(bus.o_beat_data), 32'(vecs[i].data));
      end
      step();
    end

    // Timeout: fill=3 then starve; count edges after the last pop edge.
    drive(3, 8'h21, 0, 1);
    step();
    drive(1, 8'h43, 0, 1);
    step();
    drive(0, 8'h00, 0, 1);
    n = 0;
    while ((bus.o_beat_valid !== 1'b1) && (n < 40)) begin
      step();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TIMEOUT));
    check("timeout_num", 32'(bus.o_beat_num), 32'd3);
    check("timeout_lane3", 32'(bus.o_beat_data[3]), 32'h0);
    check("timeout_data", 32'(bus.o_beat_data), 32'h0321);
    step();
    check("timeout_drop", 32'(bus.o_beat_valid), 32'h0);
    check("timeout_idle_busy", 32'(bus.o_busy), 32'h0);

    // Backpressure: full beat held with ready=0 while the FIFO has plenty.
    drive(8, 8'h21, 0, 0);
    step();
    drive(8, 8'h43, 0, 0);
    step();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_valid", c), 32'(bus.o_beat_valid), 32'h1);
      check($sformatf("bp%0d_data", c),  32'(bus.o_beat_data),  32'h4321);
      check($sformatf("bp%0d_num", c),   32'(bus.o_beat_num),   32'd4);
      check($sformatf("bp%0d_pop", c),   32'(bus.o_fifo_pop),   32'h0);
      step();
    end
    drive(8, 8'h43, 0, 1);
    #1;
    check("bp_accept_pop", 32'(bus.o_fifo_pop), 32'h0);
    step();
    drive(8, 8'hBA, 0, 0);
    #1;
    check("bp_after_valid", 32'(bus.o_beat_valid), 32'h0);
    check("bp_resume_pop", 32'(bus.o_fifo_pop), 32'h3);
    step();
    drive(8, 8'hDC, 0, 0);
    step();
    check("rs_pre_valid", 32'(bus.o_beat_valid), 32'h1);
    check("rs_pre_data", 32'(bus.o_beat_data), 32'hDCBA);

    // Reset while a full beat is pending.
    rst = 1'b1;
    #1;
    check("rs_pop_in_reset", 32'(bus.o_fifo_pop), 32'h0);
    step();
    rst = 1'b0;
    drive(0, 8'h00, 0, 1);
    #1;
    check("rs_valid", 32'(bus.o_beat_valid), 32'h0);
    check("rs_num", 32'(bus.o_beat_num), 32'h0);
    check("rs_data", 32'(bus.o_beat_data), 32'h0);
    check("rs_busy", 32'(bus.o_busy), 32'h0);
    check("rs_pop", 32'(bus.o_fifo_pop), 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("rs_quiet%0d", c), 32'(bus.o_beat_valid), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
